bp_stream_pump_out_arbiter: RTL and testbench

- Shares one BedRock memory stream output bus among num_req_p stream-pump-out producers.
- Each producer presents a header, a data beat, a valid and a lock. The arbiter grants one producer at a time, round-robin.
- A grant is held across a locked multi-beat stream until the final beat (lock low) is accepted, so beats from different streams never interleave.
- Sits between the per-FSM stream pumps and the shared network or DMA injection port.

---
 rtl/bp_stream_pump_out_arbiter.sv | 131 +++++++++++++
 tb/tb_bp_stream_pump_out_arbiter.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/bp_stream_pump_out_arbiter.sv
// Round-robin arbiter sharing one BedRock stream output bus; a grant is held across locked beats.
// Define BP_STREAM_ARB_FIXED_PRIO_EN for lowest-index-wins selection instead of round-robin.
module bp_stream_pump_out_arbiter #(
  parameter int num_req_p      = 2,
  parameter int header_width_p = 64,
  parameter int data_width_p   = 64,
  localparam int lg_num_req_lp = (num_req_p > 1) ? $clog2(num_req_p) : 1
) (
  input  logic                                  clk_i,
  input  logic                                  reset_n_i,
  input  logic [num_req_p*header_width_p-1:0]   req_header_i,
  input  logic [num_req_p*data_width_p-1:0]     req_data_i,
  input  logic [num_req_p-1:0]                  req_v_i,
  input  logic [num_req_p-1:0]                  req_lock_i,
  output logic [num_req_p-1:0]                  req_yumi_o,
  output logic [header_width_p-1:0]             mem_header_o,
  output logic [data_width_p-1:0]               mem_data_o,
  output logic                                  mem_v_o,
  output logic                                  mem_lock_o,
  input  logic                                  mem_yumi_i,
  output logic [num_req_p-1:0]                  grant_o,
  output logic                                  locked_o
);

  typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_e;

  logic [num_req_p-1:0][header_width_p-1:0] hdr;
  logic [num_req_p-1:0][data_width_p-1:0]   dat;
  assign hdr = req_header_i;
  assign dat = req_data_i;

  state_e                   state_r, state_n;
  logic [lg_num_req_lp-1:0] owner_r, owner_n, sel;
  logic                     has_sel, accept;
`ifndef BP_STREAM_ARB_FIXED_PRIO_EN
  logic [lg_num_req_lp-1:0] rr_ptr_r, rr_n, sel_nxt;
  int                       idx;
`endif

  // Selection: owner while locked, otherwise first valid requester in scan order.
  always_comb begin
    sel     = '0;
    has_sel = 1'b0;
`ifndef BP_STREAM_ARB_FIXED_PRIO_EN
    idx     = 0;
`endif
    if (state_r == LOCKED) begin
      sel     = owner_r;
      has_sel = 1'b1;
    end else begin
      for (int i = 0; i < num_req_p; i++) begin
`ifdef BP_STREAM_ARB_FIXED_PRIO_EN
        if (!has_sel && req_v_i[i]) begin
          has_sel = 1'b1;
          sel     = lg_num_req_lp'(i);
        end
`else
        idx = int'(rr_ptr_r) + i;
        if (idx >= num_req_p) idx = idx - num_req_p;
        if (!has_sel && req_v_i[idx]) begin
          has_sel = 1'b1;
          sel     = lg_num_req_lp'(idx);
        end
`endif
      end
    end
  end

  always_comb begin
    grant_o      = '0;
    req_yumi_o   = '0;
    mem_header_o = '0;
    mem_data_o   = '0;
    mem_lock_o   = 1'b0;
    mem_v_o      = 1'b0;
    if (has_sel) begin
      grant_o[sel]    = 1'b1;
      mem_header_o    = hdr[sel];
      mem_data_o      = dat[sel];
      mem_lock_o      = req_lock_i[sel];
      mem_v_o         = req_v_i[sel];
      // A yumi during an owner bubble is dropped rather than forwarded.
      req_yumi_o[sel] = mem_yumi_i & req_v_i[sel];
    end
  end

  assign accept   = mem_v_o & mem_yumi_i;
  assign locked_o = (state_r == LOCKED);

`ifndef BP_STREAM_ARB_FIXED_PRIO_EN
  assign sel_nxt = (sel == lg_num_req_lp'(num_req_p - 1)) ? '0 : sel + 1'b1;
`endif

  always_comb begin
    state_n = state_r;
    owner_n = owner_r;
`ifndef BP_STREAM_ARB_FIXED_PRIO_EN
    rr_n    = rr_ptr_r;
`endif
    if (accept) begin
      if (mem_lock_o) begin
        state_n = LOCKED;
        owner_n = sel;
      end else begin
        state_n = IDLE;
`ifndef BP_STREAM_ARB_FIXED_PRIO_EN
        rr_n    = sel_nxt;
`endif
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r  <= IDLE;
      owner_r  <= '0;
`ifndef BP_STREAM_ARB_FIXED_PRIO_EN
      rr_ptr_r <= '0;
`endif
    end else begin
      state_r  <= state_n;
      owner_r  <= owner_n;
`ifndef BP_STREAM_ARB_FIXED_PRIO_EN
      rr_ptr_r <= rr_n;
`endif
    end
  end

  a_yumi_needs_v: assert property (@(posedge clk_i) disable iff (!reset_n_i) mem_yumi_i |-> mem_v_o);

endmodule

// File: tb/tb_bp_stream_pump_out_arbiter.sv
// Directed bench for bp_stream_pump_out_arbiter (2 requesters) with a beat scoreboard.
module tb_bp_stream_pump_out_arbiter;
  localparam int N = 2;
  localparam int HW = 64;
  localparam int DW = 64;
`ifdef BP_STREAM_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic [N*HW-1:0] req_header = '0;
  logic [N*DW-1:0] req_data = '0;
  logic [N-1:0]    req_v = '0, req_lock = '0, req_yumi, grant;
  logic [HW-1:0]   mem_header;
  logic [DW-1:0]   mem_data;
  logic            mem_v, mem_lock, locked;
  logic            mem_yumi = 1'b0;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct { logic [HW-1:0] h; logic [DW-1:0] d; } beat_t;
  beat_t q[$];

  bp_stream_pump_out_arbiter #(.num_req_p(N), .header_width_p(HW), .data_width_p(DW)) dut (
    .clk_i(clk), .reset_n_i(rst_n),
    .req_header_i(req_header), .req_data_i(req_data),
    .req_v_i(req_v), .req_lock_i(req_lock), .req_yumi_o(req_yumi),
    .mem_header_o(mem_header), .mem_data_o(mem_data),
    .mem_v_o(mem_v), .mem_lock_o(mem_lock), .mem_yumi_i(mem_yumi),
    .grant_o(grant), .locked_o(locked)
  );

  always #5 clk = ~clk;

  function automatic logic [HW-1:0] hv(int k, int i);
    return {32'(k + 32'hA000), 32'(i)};
  endfunction
  function automatic logic [DW-1:0] dv(int k, int i);
    return {32'(k + 32'hD000), 32'(i)};
  endfunction

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(int k, logic v, logic lk, int i);
    req_header[k*HW +: HW] = hv(k, i);
    req_data[k*DW +: DW]   = dv(k, i);
    req_v[k]    = v;
    req_lock[k] = lk;
  endtask

  task automatic push(int k, int i);
    beat_t b;
    b.h = hv(k, i);
    b.d = dv(k, i);
    q.push_back(b);
  endtask

  // Wait to mid-cycle and retire any beat accepted this cycle against the scoreboard.
  task automatic settle();
    beat_t b;
    @(negedge clk);
    if (mem_v && mem_yumi) begin
      if (q.size() == 0) begin
        chk("sb_empty", 64'(q.size()), 64'd1);
      end else begin
        b = q.pop_front();
        chk("sb_header", mem_header, b.h);
        chk("sb_data", mem_data, b.d);
      end
    end
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Async reset pulsed mid-cycle, then idle.
    #2 rst_n = 1'b0;
    #1;
    chk("rst_grant", 64'(grant), 64'd0);
    chk("rst_v", 64'(mem_v), 64'd0);
    chk("rst_locked", 64'(locked), 64'd0);
    #14 rst_n = 1'b1;
    settle();
    chk("idle_grant", 64'(grant), 64'd0);
    chk("idle_v", 64'(mem_v), 64'd0);
    chk("idle_yumi", 64'(req_yumi), 64'd0);
    chk("idle_hdr", mem_header, 64'd0);
    adv();

    // Round-robin single beats.
    for (int i = 0; i < 4; i++) begin
      int w;
      w = FIXED ? 0 : (i % 2);
      set_req(0, 1'b1, 1'b0, i);
      set_req(1, 1'b1, 1'b0, i);
      mem_yumi = 1'b1;
      push(w, i);
      settle();
      chk("rr_grant", 64'(grant), 64'(1 << w));
      chk("rr_yumi", 64'(req_yumi), 64'(1 << w));
      adv();
    end

    // Requester 0 alone moves the pointer to requester 1.
    set_req(0, 1'b1, 1'b0, 10);
    set_req(1, 1'b0, 1'b0, 10);
    push(0, 10);
    settle();
    chk("pre_grant", 64'(grant), 64'd1);
    adv();

    // Locked 4-beat stream from requester 1 with requester 0 contending.
    for (int i = 0; i < 4; i++) begin
      set_req(0, (i == 0) ? !FIXED : 1'b1, 1'b0, 20 + i);
      set_req(1, 1'b1, (i != 3), 20 + i);
      push(1, 20 + i);
      settle();
      chk("lk_grant", 64'(grant), 64'd2);
      chk("lk_locked", 64'(locked), (i == 0) ? 64'd0 : 64'd1);
      chk("lk_mlock", 64'(mem_lock), (i != 3) ? 64'd1 : 64'd0);
      adv();
    end
    set_req(0, 1'b1, 1'b0, 30);
    set_req(1, 1'b0, 1'b0, 30);
    push(0, 30);
    settle();
    chk("rel_locked", 64'(locked), 64'd0);
    chk("rel_grant", 64'(grant), 64'd1);
    adv();

    // Owner bubble: requester 0 locks, then drops valid.
    set_req(0, 1'b1, 1'b1, 40);
    push(0, 40);
    settle();
    chk("bub_first", 64'(grant), 64'd1);
    adv();
    mem_yumi = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_req(0, 1'b0, 1'b1, 41 + i);
      set_req(1, 1'b1, 1'b0, 41 + i);
      settle();
      chk("bub_v", 64'(mem_v), 64'd0);
      chk("bub_grant", 64'(grant), 64'd1);
      chk("bub_yumi", 64'(req_yumi), 64'd0);
      chk("bub_locked", 64'(locked), 64'd1);
      adv();
    end
    set_req(0, 1'b1, 1'b0, 45);
    mem_yumi = 1'b1;
    push(0, 45);
    settle();
    chk("bub_resume", 64'(grant), 64'd1);
    adv();

    // Backpressure on requester 1.
    set_req(0, 1'b0, 1'b0, 50);
    set_req(1, 1'b1, 1'b0, 50);
    mem_yumi = 1'b0;
    for (int i = 0; i < 5; i++) begin
      settle();
      chk("bp_hdr", mem_header, hv(1, 50));
      chk("bp_data", mem_data, dv(1, 50));
      chk("bp_grant", 64'(grant), 64'd2);
      chk("bp_locked", 64'(locked), 64'd0);
      adv();
    end
    mem_yumi = 1'b1;
    push(1, 50);
    settle();
    adv();
    set_req(0, 1'b1, 1'b0, 51);
    set_req(1, 1'b1, 1'b0, 51);
    mem_yumi = 1'b0;
    settle();
    chk("bp_after", 64'(grant), 64'd1);
    adv();

    // Reset mid-stream drops ownership immediately.
    set_req(0, 1'b1, 1'b1, 60);
    set_req(1, 1'b0, 1'b0, 60);
    mem_yumi = 1'b1;
    push(0, 60);
    settle();
    adv();
    req_v = '0;
    mem_yumi = 1'b0;
    chk("mid_locked", 64'(locked), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_locked", 64'(locked), 64'd0);
    chk("mid_rst_grant", 64'(grant), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    adv();
    set_req(0, 1'b1, 1'b0, 70);
    set_req(1, 1'b1, 1'b0, 70);
    settle();
    chk("post_rst_grant", 64'(grant), 64'd1);
    chk("post_rst_locked", 64'(locked), 64'd0);
    adv();

    chk("sb_drained", 64'(q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
